// File: rtl/seg_scan_reader.sv
// Reader for a scanned seven-segment display bus: debounces each (seg, an) sample,
// decodes the stable pattern to BCD per digit position and flags completed frames.
module seg_scan_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    digit_stb,
  output logic [2:0]              digit_idx,
  output logic [3:0]              digit_val,
  output logic                    err_sticky,
  output logic                    frame_stb
);

  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DIG_W   = 4 * NUM_DIGITS;
  localparam logic [3:0]  NO_DIG  = 4'hF;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIG_W-1:0]      digits_q, digits_d;
  logic [NUM_DIGITS-1:0] valid_q, valid_d;
  logic                  stb_q, stb_d;
  logic [2:0]            idx_q, idx_d;
  logic [3:0]            val_q, val_d;
  logic                  err_q, err_d;
  logic                  frame_q, frame_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;

  logic [3:0]            ones;
  logic                  onehot;
  logic [IDX_W-1:0]      idx_cand;
  logic [3:0]            dec_val;
  logic                  dec_legal;
  logic                  dec_blank;
  logic                  capture;
  logic [NUM_DIGITS-1:0] mask_nx;

  // Population count of the enables and index of the active one
  always_comb begin
    ones     = '0;
    idx_cand = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an[i]) begin
        ones     = ones + 4'd1;
        idx_cand = IDX_W'(i);
      end
    end
    onehot = (ones == 4'd1);
  end

  // Segment decode of the held candidate (a..g in seg[6:0])
  always_comb begin
    dec_val   = NO_DIG;
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    unique case (seg_q)
      7'b1111110: dec_val = 4'd0;
      7'b0110000: dec_val = 4'd1;
      7'b1101101: dec_val = 4'd2;
      7'b1111001: dec_val = 4'd3;
      7'b0110011: dec_val = 4'd4;
      7'b1011011: dec_val = 4'd5;
      7'b1011111: dec_val = 4'd6;
      7'b1110000: dec_val = 4'd7;
      7'b1111111: dec_val = 4'd8;
      7'b1111011: dec_val = 4'd9;
      7'b0000000: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default:    dec_legal = 1'b0;
    endcase
  end

  // Next-state: candidate tracking, then capture side effects
  always_comb begin
    seg_d    = seg_q;
    an_d     = an_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    stb_d    = 1'b0;
    idx_d    = idx_q;
    val_d    = val_q;
    err_d    = err_q;
    frame_d  = 1'b0;
    mask_d   = mask_q;
    capture  = 1'b0;
    mask_nx  = mask_q | an_q;

    if (!onehot) begin
      seg_d = seg;
      an_d  = an;
      cnt_d = '0;
    end else if ((seg != seg_q) || (an != an_q)) begin
      seg_d = seg;
      an_d  = an;
      cnt_d = CNT_W'(1);
    end else if (cnt_q < CNT_MAX) begin
      cnt_d   = cnt_q + CNT_W'(1);
      capture = (cnt_d == CNT_MAX);
    end

    if (clr_err) begin
      err_d = 1'b0;
    end

    // Capture uses the candidate, which equals the current inputs here
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (an_q[i]) begin
          digits_d[4*i +: 4] = dec_legal ? dec_val : NO_DIG;
          valid_d[i]         = dec_legal;
        end
      end
      stb_d = 1'b1;
      idx_d = 3'(idx_cand_q());
      val_d = dec_legal ? dec_val : NO_DIG;
      if (!dec_legal && !dec_blank) begin
        err_d = 1'b1;
      end
      if (&mask_nx) begin
        frame_d = 1'b1;
        mask_d  = '0;
      end else begin
        mask_d  = mask_nx;
      end
    end
  end

  // Index of the held candidate's enable bit
  function automatic logic [IDX_W-1:0] idx_cand_q();
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_q[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q    <= '0;
      an_q     <= '0;
      cnt_q    <= '0;
      digits_q <= {NUM_DIGITS{NO_DIG}};
      valid_q  <= '0;
      stb_q    <= 1'b0;
      idx_q    <= '0;
      val_q    <= '0;
      err_q    <= 1'b0;
      frame_q  <= 1'b0;
      mask_q   <= '0;
    end else begin
      seg_q    <= seg_d;
      an_q     <= an_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      stb_q    <= stb_d;
      idx_q    <= idx_d;
      val_q    <= val_d;
      err_q    <= err_d;
      frame_q  <= frame_d;
      mask_q   <= mask_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_stb   = stb_q;
  assign digit_idx   = idx_q;
  assign digit_val   = val_q;
  assign err_sticky  = err_q;
  assign frame_stb   = frame_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed and random stimulus for seg_scan_reader, checked every cycle against a
// history-window reference model of the capture rules.
module tb_seg_scan_reader;
  localparam int N = 4;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [6:0]     seg;
  logic [N-1:0]   an;
  logic           clr_err;
  logic [4*N-1:0] digits;
  logic [N-1:0]   digit_valid;
  logic           digit_stb;
  logic [2:0]     digit_idx;
  logic [3:0]     digit_val;
  logic           err_sticky;
  logic           frame_stb;

  always #5 clk = ~clk;

  seg_scan_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .clr_err(clr_err),
    .digits(digits), .digit_valid(digit_valid), .digit_stb(digit_stb),
    .digit_idx(digit_idx), .digit_val(digit_val), .err_sticky(err_sticky),
    .frame_stb(frame_stb)
  );

  localparam logic [6:0] PAT [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                      7'b1111111, 7'b1111011};

  int n_cmp = 0;
  int n_bad = 0;
  int n_stb = 0;
  int n_frm = 0;

  // Reference model state
  logic [N+6:0]   hist[$];
  logic [4*N-1:0] m_digits;
  logic [N-1:0]   m_valid, m_mask;
  logic           m_stb, m_frame, m_err;
  logic [2:0]     m_idx;
  logic [3:0]     m_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // -1 illegal, 16 blank, else the BCD value
  function automatic int decode(input logic [6:0] s);
    for (int v = 0; v < 10; v++) if (s == PAT[v]) return v;
    if (s == 7'b0) return 16;
    return -1;
  endfunction

  task automatic model(input logic [6:0] s, input logic [N-1:0] a, input logic c, input logic r);
    bit cap;
    int i, d, sz;
    m_stb   = 1'b0;
    m_frame = 1'b0;
    if (r) begin
      hist.delete();
      m_digits = '1; m_valid = '0; m_mask = '0; m_err = 1'b0;
      m_idx = '0; m_val = '0;
      return;
    end
    hist.push_back({a, s});
    if (hist.size() > S + 1) void'(hist.pop_front());
    sz  = hist.size();
    // Capture: last S samples identical and one-hot, and the sample before them differs
    cap = ($countones(a) == 1) && (sz >= S);
    if (cap) begin
      for (int k = sz - S; k < sz; k++) if (hist[k] != hist[sz-1]) cap = 0;
      if (sz == S + 1 && hist[0] == hist[1]) cap = 0;
    end
    if (c) m_err = 1'b0;
    if (cap) begin
      i = 0;
      for (int k = 0; k < N; k++) if (a[k]) i = k;
      d = decode(s);
      m_stb = 1'b1;
      m_idx = 3'(i);
      if (d >= 0 && d < 10) begin
        m_digits[4*i +: 4] = 4'(d); m_valid[i] = 1'b1; m_val = 4'(d);
      end else begin
        m_digits[4*i +: 4] = 4'hF; m_valid[i] = 1'b0; m_val = 4'hF;
        if (d < 0) m_err = 1'b1;
      end
      m_mask[i] = 1'b1;
      if (&m_mask) begin
        m_frame = 1'b1;
        m_mask  = '0;
      end
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [N-1:0] a, input logic c, input logic r);
    seg = s; an = a; clr_err = c; reset = r;
    @(posedge clk);
    #1;
    model(s, a, c, r);
    if (digit_stb) n_stb++;
    if (frame_stb) n_frm++;
    chk("digit_stb", 32'(digit_stb), 32'(m_stb));
    chk("frame_stb", 32'(frame_stb), 32'(m_frame));
    chk("err_sticky", 32'(err_sticky), 32'(m_err));
    chk("digits", 32'(digits), 32'(m_digits));
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    if (m_stb) begin
      chk("digit_idx", 32'(digit_idx), 32'(m_idx));
      chk("digit_val", 32'(digit_val), 32'(m_val));
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [N-1:0] a, input int n);
    for (int k = 0; k < n; k++) step(s, a, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0]   rs;
    logic [N-1:0] ra;
    int           len, sel;
    seg = '0; an = '0; clr_err = 1'b0; reset = 1'b1;

    // Reset state
    step(7'b0, '0, 1'b0, 1'b1);
    step(7'b0, '0, 1'b0, 1'b1);
    chk("rst_digits", 32'(digits), 32'hFFFF);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_idx_val", {25'b0, digit_idx, digit_val}, 32'h0);

    // 1: single capture after exactly S cycles
    n_stb = 0;
    hold(7'b1101101, 4'b0001, 3);
    chk("t1_no_early", 32'(n_stb), 32'd0);
    hold(7'b1101101, 4'b0001, 1);
    chk("t1_stb", 32'(digit_stb), 32'd1);
    chk("t1_val", {28'b0, digit_val}, 32'd2);
    chk("t1_digits", 32'(digits), 32'hFFF2);

    // 2: interrupted run, then saturation
    n_stb = 0;
    hold(7'b1111001, 4'b0001, 1);
    hold(7'b1101101, 4'b0001, 3);
    hold(7'b1111001, 4'b0001, 4);
    chk("t2_one_stb", 32'(n_stb), 32'd1);
    hold(7'b1111001, 4'b0001, 20);
    chk("t2_no_repeat", 32'(n_stb), 32'd1);

    // 3: full frame scan 9, 1, blank, 7
    step(7'b0, '0, 1'b0, 1'b1);
    n_stb = 0; n_frm = 0;
    hold(PAT[9], 4'b0001, 5);
    hold(PAT[1], 4'b0010, 5);
    hold(7'b0,   4'b0100, 5);
    chk("t3_no_frame_yet", 32'(n_frm), 32'd0);
    hold(PAT[7], 4'b1000, 4);
    chk("t3_frame", 32'(frame_stb), 32'd1);
    hold(PAT[7], 4'b1000, 1);
    chk("t3_digits", 32'(digits), 32'h7F19);
    chk("t3_valid", 32'(digit_valid), 32'b1011);
    chk("t3_counts", {n_stb[15:0], n_frm[15:0]}, {16'd4, 16'd1});

    // 4: illegal pattern, clear, then clear colliding with new error
    hold(7'b1000001, 4'b0100, 4);
    chk("t4_val", {25'b0, digit_idx, digit_val}, {25'b0, 3'd2, 4'hF});
    chk("t4_err", 32'(err_sticky), 32'd1);
    step(7'b1000001, 4'b0100, 1'b1, 1'b0);
    chk("t4_clr", 32'(err_sticky), 32'd0);
    hold(7'b1000001, 4'b0000, 1);
    hold(7'b1000001, 4'b0100, 3);
    step(7'b1000001, 4'b0100, 1'b1, 1'b0);
    chk("t4_err_wins", 32'(err_sticky), 32'd1);

    // 5: non-one-hot enables and fast toggling
    n_stb = 0;
    hold(PAT[5], 4'b0110, 10);
    hold(PAT[5], 4'b0000, 10);
    for (int k = 0; k < 20; k++) hold(PAT[5], (k % 2) ? 4'b0010 : 4'b0001, 1);
    chk("t5_no_stb", 32'(n_stb), 32'd0);

    // 6: reset in mid-run restarts the count
    hold(PAT[6], 4'b0010, 3);
    step(PAT[6], 4'b0010, 1'b0, 1'b1);
    chk("t6_rst", {err_sticky, digit_valid, digits}, {1'b0, 4'b0, 16'hFFFF});
    n_stb = 0;
    hold(PAT[6], 4'b0010, S - 1);
    chk("t6_no_early", 32'(n_stb), 32'd0);
    hold(PAT[6], 4'b0010, 1);
    chk("t6_stb", {28'b0, digit_val}, 32'd6);

    // Random scan traffic
    for (int t = 0; t < 400; t++) begin
      sel = int'($urandom_range(0, 15));
      if (sel < 10)       rs = PAT[sel];
      else if (sel < 12)  rs = 7'b0;
      else                rs = 7'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 8) ra = 4'(1 << $urandom_range(0, N - 1));
      else         ra = 4'($urandom);
      len = int'($urandom_range(1, 2 * S));
      for (int k = 0; k < len; k++)
        step(rs, ra, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
